// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encodings and LED constant for the countdown controller
package countdown_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;
  localparam logic [15:0] LED_ALL_ON = 16'hFFFF;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running prescaler with enable and clear; tick while all ones
module tick_prescaler #(
  parameter int W = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (!rst || clr) cnt_q <= '0;
    else if (en) cnt_q <= cnt_q + 1'b1;
  assign tick = &cnt_q;
endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: start/pause/clear countdown FSM with prescaled tick
// Define COUNTDOWN_CTRL_AUTORELOAD_EN to restart automatically one tick period after DONE.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_W = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pb,
  input  logic        clear_pb,
  input  logic        cnt_zero,
  output logic        load,
  output logic        dec,
  output logic [1:0]  state,
  output logic [15:0] led
);
  state_t state_q;
  logic load_q, dec_q, tick, pre_en, pre_clr;
  logic [15:0] led_q;
  // A start or clear edge must not advance the prescaler, so a pause freezes the pre-pause value
`ifdef COUNTDOWN_CTRL_AUTORELOAD_EN
  assign pre_en  = !clear_pb && ((state_q == ST_RUN && !start_pb) || state_q == ST_DONE);
  assign pre_clr = clear_pb || state_q == ST_IDLE || (state_q == ST_DONE && tick);
`else
  assign pre_en  = !clear_pb && state_q == ST_RUN && !start_pb;
  assign pre_clr = clear_pb || state_q == ST_IDLE;
`endif
  tick_prescaler #(.W(TICK_W)) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (pre_en),
    .clr (pre_clr),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      load_q  <= 1'b1;
      dec_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      load_q <= 1'b0;
      dec_q  <= 1'b0;
      if (clear_pb) begin
        state_q <= ST_IDLE;
        load_q  <= 1'b1;
        led_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE:  if (start_pb) state_q <= ST_RUN;
          ST_RUN:
            if (start_pb) state_q <= ST_PAUSE;
            else if (tick && cnt_zero) begin
              state_q <= ST_DONE;
              led_q   <= LED_ALL_ON;
            end else if (tick) dec_q <= 1'b1;
          ST_PAUSE: if (start_pb) state_q <= ST_RUN;
          ST_DONE: begin
`ifdef COUNTDOWN_CTRL_AUTORELOAD_EN
            if (tick) begin
              state_q <= ST_RUN;
              load_q  <= 1'b1;
              led_q   <= '0;
            end
`endif
          end
        endcase
      end
    end
  end
  assign load  = load_q;
  assign dec   = dec_q;
  assign state = state_q;
  assign led   = led_q;
endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 SHALL have parameter TICK_W, default 27, meaning the prescaler width; one tick occurs every 2^TICK_W RUN-state clk cycles.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start_pb  input  1  single-cycle start/pause-toggle pulse, already debounced and one-pulsed.
REQ-005 SHALL have port clear_pb  input  1  single-cycle clear pulse.
REQ-006 SHALL have port cnt_zero  input  1  countdown datapath reports the value is 00.
REQ-007 SHALL have port load  output  1  one-cycle strobe; the datapath reloads its preset.
REQ-008 SHALL have port dec  output  1  one-cycle strobe; the datapath decrements by one.
REQ-009 SHALL have port state  output  2  current FSM state encoding.
REQ-010 SHALL have port led  output  16  status LEDs.

Function
REQ-011 SHALL implement FSM states IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-012 SHALL advance from IDLE to RUN on start_pb, with the prescaler cleared to 0.
REQ-013 SHALL increment the prescaler only in RUN; tick = prescaler at all-ones, wrapping to 0 on the next cycle.
REQ-014 SHALL, in RUN on tick with cnt_zero=0, assert dec for exactly the following cycle.
REQ-015 SHALL, in RUN on tick with cnt_zero=1, enter DONE next cycle with no dec.
REQ-016 SHALL move RUN to PAUSE on start_pb; start_pb beats a coincident tick (no dec, no DONE).
REQ-017 SHALL freeze the prescaler in PAUSE and return to RUN on start_pb with the prescaler value retained.
REQ-018 SHALL ignore start_pb in DONE.
REQ-019 SHALL, on clear_pb in any state, enter IDLE, clear the prescaler and assert load for exactly the following cycle.
REQ-020 SHALL give clear_pb priority over start_pb and tick in the same cycle.
REQ-021 SHALL drive led to 16'hFFFF in DONE and 16'h0000 in all other states; led is registered and updates with state.
REQ-022 SHALL register load and dec; they are never asserted in the same cycle.
REQ-023 SHALL never assert dec outside the cycle following a RUN tick.

Reset
REQ-024 SHALL, on rst=0 at a clk edge, set state=IDLE, prescaler=0, dec=0, led=0 and load=1.
REQ-025 SHALL drop load to 0 on the first clk edge after rst returns to 1.
REQ-026 SHALL give reset priority over all inputs, including mid-RUN and mid-DONE.

Configuration
REQ-027 SHALL, with COUNTDOWN_CTRL_AUTORELOAD_EN defined, count one full tick period in DONE, then assert load for one cycle and enter RUN with the prescaler cleared and led=0.
REQ-028 SHALL, without COUNTDOWN_CTRL_AUTORELOAD_EN, hold DONE until clear_pb or reset, with the prescaler frozen.

Structure
REQ-029 SHALL take the state encodings and constant LED_ALL_ON=16'hFFFF from shared package countdown_pkg.
REQ-030 SHALL place the prescaler in sub-module tick_prescaler, with inputs clk, rst, en and clr, and output tick.

Verification (TICK_W=2, tick every 4 RUN cycles)
REQ-031 SHALL verify: reset release -> load=1 during reset, 0 after; state=00; led=0.
REQ-032 SHALL verify: start_pb, cnt_zero=0 -> state=01; dec pulses at RUN cycles 4, 8, 12; each pulse is one cycle wide.
REQ-033 SHALL verify: start_pb at RUN cycle 2, then start_pb 10 cycles later -> state=10 with no dec while paused; next dec 2 cycles after resume.
REQ-034 SHALL verify: cnt_zero=1 at a tick -> state=11 and led=FFFF next cycle, no dec; a subsequent start_pb leaves state=11.
REQ-035 SHALL verify: clear_pb and start_pb in the same cycle while in RUN -> state=00, load=1 for one cycle, no dec.
REQ-036 SHALL verify, with the macro defined: DONE followed by 4 cycles -> load pulse, then state=01 and led=0.
